lane_pipe_mirror: RTL and testbench

LANE_PIPE_MIRROR -- requirements
Module: lane_pipe_mirror

---
 rtl/lane_pipe_mirror.sv | 71 +++++++
 tb/tb_lane_pipe_mirror.sv | 127 ++++++++++++
 2 files changed

// File: rtl/lane_pipe_mirror.sv
// lane_pipe_mirror: per-lane DEPTH-stage capture pipelines with fill/valid tracking and per-lane change flags
// Ports:
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset, overrides clear
//   clear   - synchronous flush of all stages, fill count and diff flags
//   data    - data[i] feeds lane i
//   lane_en - per-lane capture enable for stage 0
//   result  - last stage of each lane
//   valid   - high once DEPTH samples have entered since reset/clear
//   fill    - samples entered since reset/clear, saturating at DEPTH
//   diff    - high for the cycle after result[i] changed while valid
module lane_pipe_mirror #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           data,
    input  logic [WIDTH-1:0]           lane_en,
    output logic [WIDTH-1:0]           result,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic [WIDTH-1:0]           diff
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);
    logic [FW-1:0] fill_q, fill_d;
    logic valid_d;
    always_comb begin
        fill_d  = clear ? '0 : (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        valid_d = fill_d == FULL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill_q <= '0;
        else     fill_q <= fill_d;
    end
    assign fill  = fill_q;
    assign valid = fill_q == FULL;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            logic [DEPTH-1:0] st_q, st_d;
            logic diff_q, diff_d, cap;
            always_comb begin
                // MODE 1 makes stage 0 sticky: once a 1 is captured it stays until flush
                cap  = (MODE == 1) ? (st_q[0] | (lane_en[i] & data[i]))
                                   : (lane_en[i] ? data[i] : st_q[0]);
                st_d = '0;
                if (!clear) begin
                    st_d[0] = cap;
                    for (int k = 1; k < DEPTH; k++) st_d[k] = st_q[k-1];
                end
                // flag a change on the output stage only in cycles where valid will be high
                diff_d = valid_d & (st_d[DEPTH-1] != st_q[DEPTH-1]);
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_q   <= '0;
                    diff_q <= 1'b0;
                end else begin
                    st_q   <= st_d;
                    diff_q <= diff_d;
                end
            end
            assign result[i] = st_q[DEPTH-1];
            assign diff[i]   = diff_q;
        end
    endgenerate
endmodule

// File: tb/tb_lane_pipe_mirror.sv
// tb_lane_pipe_mirror: randomized and directed checks of lane_pipe_mirror against a delay-line reference model
module tb_lane_pipe_mirror;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic [3:0] data = '0, lane_en = '0;
    logic [3:0] result_a, diff_a, result_b, diff_b;
    logic [1:0] fill_a, fill_b;
    logic valid_a, valid_b;
    int n_chk = 0, n_err = 0;

    lane_pipe_mirror #(.WIDTH(4), .DEPTH(2), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .data(data), .lane_en(lane_en),
        .result(result_a), .valid(valid_a), .fill(fill_a), .diff(diff_a));
    lane_pipe_mirror #(.WIDTH(4), .DEPTH(3), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .data(data), .lane_en(lane_en),
        .result(result_b), .valid(valid_b), .fill(fill_b), .diff(diff_b));

    always #5 clk = ~clk;

    logic [3:0] sa, sb, ra, rb, da, db;
    logic [3:0] ha[$], hb[$];
    int cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sa = '0; sb = '0; ra = '0; rb = '0; da = '0; db = '0; cnt = 0;
        ha.delete(); hb.delete();
        repeat (2) ha.push_back(4'h0);
        repeat (3) hb.push_back(4'h0);
    endtask

    task automatic model_step(input logic [3:0] d, input logic [3:0] en, input logic clr);
        logic [3:0] na, nb;
        if (clr) model_reset();
        else begin
            sa = (sa & ~en) | (d & en);
            sb = sb | (d & en);
            ha.push_back(sa); void'(ha.pop_front());
            hb.push_back(sb); void'(hb.pop_front());
            if (cnt < 100) cnt++;
            na = ha[0];
            nb = hb[0];
            da = (cnt >= 2) ? (na ^ ra) : 4'h0;
            db = (cnt >= 3) ? (nb ^ rb) : 4'h0;
            ra = na;
            rb = nb;
        end
    endtask

    task automatic check_all();
        chk("result_a", 32'(result_a), 32'(ra));
        chk("fill_a",   32'(fill_a),   32'(cnt < 2 ? cnt : 2));
        chk("valid_a",  32'(valid_a),  32'(cnt >= 2));
        chk("diff_a",   32'(diff_a),   32'(da));
        chk("result_b", 32'(result_b), 32'(rb));
        chk("fill_b",   32'(fill_b),   32'(cnt < 3 ? cnt : 3));
        chk("valid_b",  32'(valid_b),  32'(cnt >= 3));
        chk("diff_b",   32'(diff_b),   32'(db));
    endtask

    task automatic step(input logic [3:0] d, input logic [3:0] en, input logic clr);
        data = d; lane_en = en; clear = clr;
        @(posedge clk);
        model_step(d, en, clr);
        #1 check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_result_a", 32'(result_a), 32'h0);
        chk("async_valid_a",  32'(valid_a),  32'h0);
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst = 1'b0;
        step(4'b1010, 4'b1111, 1'b0);
        chk("r027_valid_1st", 32'(valid_a), 32'h0);
        step(4'b1010, 4'b1111, 1'b0);
        chk("r027_result", 32'(result_a), 32'b1010);
        chk("r027_fill",   32'(fill_a),   32'd2);
        chk("r027_valid",  32'(valid_a),  32'h1);
        step(4'b0101, 4'b0011, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("r028_result", 32'(result_a), 32'b1001);
        chk("r028_diff",   32'(diff_a),   32'b0011);
        step(4'b0000, 4'b0000, 1'b0);
        chk("r028_diff_off", 32'(diff_a), 32'h0);
        step(4'b0000, 4'b1111, 1'b1);
        step(4'b0001, 4'b1111, 1'b0);
        step(4'b0100, 4'b1111, 1'b0);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b1111, 1'b0);
        chk("r029_sticky", 32'(result_b), 32'b0101);
        step(4'b0000, 4'b1111, 1'b1);
        chk("r029_clr_result", 32'(result_b), 32'h0);
        chk("r029_clr_fill",   32'(fill_b),   32'h0);
        chk("r029_clr_valid",  32'(valid_b),  32'h0);
        step(4'b1111, 4'b1111, 1'b1);
        chk("r030_fill", 32'(fill_a), 32'h0);
        step(4'b1111, 4'b1111, 1'b0);
        chk("r030_fill_next", 32'(fill_a), 32'h1);
        step(4'b1111, 4'b1111, 1'b0);
        step(4'b1111, 4'b1111, 1'b0);
        chk("r031_pre", 32'(result_a), 32'b1111);
        async_reset();
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
            if (n % 97 == 96) async_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
